// File: rtl/ram8.sv
// ram8: eight-word bank of WIDTH-bit load-enabled registers.
// A 1-of-8 decoder steers the load strobe to the addressed word.
// An 8-way multiplexer returns the addressed word combinationally.
// Reset is synchronous and active-high, and it wins over a same-edge write.

// One storage word: holds its value unless loaded, clears on reset.
module ram8_word #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Word storage: reset clears, load captures, otherwise hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

module ram8 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  // One-hot load decode of a 3-bit address; zero vector when load is low.
  function automatic logic [7:0] load_decode(input logic i_en, input logic [2:0] i_addr);
    logic [7:0] v_sel;
    v_sel = 8'h00;
    case (i_addr)
      3'd0:    v_sel = 8'b0000_0001;
      3'd1:    v_sel = 8'b0000_0010;
      3'd2:    v_sel = 8'b0000_0100;
      3'd3:    v_sel = 8'b0000_1000;
      3'd4:    v_sel = 8'b0001_0000;
      3'd5:    v_sel = 8'b0010_0000;
      3'd6:    v_sel = 8'b0100_0000;
      3'd7:    v_sel = 8'b1000_0000;
      default: v_sel = 8'h00;
    endcase
    if (i_en) begin
      return v_sel;
    end else begin
      return 8'h00;
    end
  endfunction

  logic [7:0]       w_load_dec;
  logic [WIDTH-1:0] w_word_q [DEPTH];

  // Load strobe steering: at most one word sees load in any cycle.
  always_comb begin
    w_load_dec = 8'h00;
    w_load_dec = load_decode(load, address);
  end

  // Storage array: one register instance per word, all sharing write data.
  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    ram8_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .i_clk   (clk),
      .i_reset (reset),
      .i_load  (w_load_dec[k]),
      .i_d     (in),
      .o_q     (w_word_q[k])
    );
  end

  // Read multiplexer: zero-latency read of the addressed word, no write-through.
  always_comb begin
    out = {WIDTH{1'b0}};
    case (address)
      3'd0:    out = w_word_q[0];
      3'd1:    out = w_word_q[1];
      3'd2:    out = w_word_q[2];
      3'd3:    out = w_word_q[3];
      3'd4:    out = w_word_q[4];
      3'd5:    out = w_word_q[5];
      3'd6:    out = w_word_q[6];
      3'd7:    out = w_word_q[7];
      default: out = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_ram8.sv
// Directed self-checking bench for ram8 with hand-computed expectations.
module tb_ram8;

  logic        clk;
  logic        reset;
  logic        load;
  logic [2:0]  address;
  logic [15:0] in;
  logic [15:0] out;

  int n_checks;
  int n_fail;

  logic [15:0] exp_mem [8];

  ram8 #(.WIDTH(16), .DEPTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .address (address),
    .in      (in),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [2:0] a, input logic [15:0] d);
    load = 1'b1;
    address = a;
    in = d;
    tick();
    load = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic sweep(input string tag);
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #1;
      check_eq($sformatf("%s_a%0d", tag, k), out, exp_mem[k]);
    end
  endtask

  initial begin
    logic [15:0] v;
    n_checks = 0;
    n_fail = 0;
    reset = 1'b0;
    load = 1'b0;
    address = 3'd0;
    in = 16'h0000;
    #2;

    // 1: reset then sweep, all zero
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) exp_mem[k] = 16'h0000;
    sweep("reset");

    // 2: write 16'h1111*k on consecutive edges
    load = 1'b1;
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      v = 16'h1111 * 16'(k);
      in = v;
      exp_mem[k] = v;
      tick();
    end
    load = 1'b0;
    sweep("fill");

    // 3: isolated writes, neighbours unchanged
    write_word(3'd3, 16'hAAAA);
    write_word(3'd4, 16'h5555);
    address = 3'd3; #1; check_eq("w3", out, 16'hAAAA);
    address = 3'd4; #1; check_eq("w4", out, 16'h5555);
    address = 3'd2; #1; check_eq("nb2", out, 16'h2222);
    address = 3'd5; #1; check_eq("nb5", out, 16'h5555);
    sweep("iso");

    // 4: no write-through before the edge
    write_word(3'd2, 16'h1234);
    #2;
    load = 1'b1;
    in = 16'hFFFF;
    address = 3'd2;
    #1;
    check_eq("pre_edge", out, 16'h1234);
    tick();
    load = 1'b0;
    check_eq("post_edge", out, 16'hFFFF);
    exp_mem[2] = 16'hFFFF;

    // reset pulse between edges has no effect
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    sweep("glitch");

    // 5: reset beats same-edge write
    reset = 1'b1;
    load = 1'b1;
    in = 16'hBEEF;
    address = 3'd5;
    tick();
    reset = 1'b0;
    load = 1'b0;
    for (int k = 0; k < 8; k++) exp_mem[k] = 16'h0000;
    sweep("rst_pri");

    // 6: load=0 with toggling data and address never modifies storage
    for (int k = 0; k < 8; k++) write_word(3'(k), 16'hA5A0 + 16'(k));
    for (int e = 0; e < 4; e++) begin
      in = (e % 2 == 0) ? 16'hFFFF : 16'h0000;
      for (int k = 0; k < 8; k++) begin
        address = 3'(k);
        #1;
      end
      tick();
      check_eq($sformatf("hold_e%0d", e), out, exp_mem[address]);
    end
    sweep("hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
